// File: rtl/fp_pkg.sv
// Shared FP32 field constants and divider state encoding.
package fp_pkg;
    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_MAX  = 255;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_W    = 8;

    // Used by the special-case export stage downstream.
    localparam logic [31:0] FP_INF_POS = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN    = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {IDLE, CALC, NORM} fp_state_e;
endpackage

// File: rtl/fp_div_round.sv
// Combinational normalise/round/pack of the raw mantissa quotient.
// FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even, otherwise truncate.
module fp_div_round
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic [QBITS-1:0]  q,
    input  logic              r_nz,
    input  logic signed [9:0] e_in,
    input  logic              sign,
    output logic [31:0]       result
);
    localparam logic signed [9:0] EMAX = 10'(FP_EXP_MAX);

    logic [FP_MANT_W-1:0] mant;
    logic [FP_MANT_W-1:0] mant_r;
    logic                 guard;
    logic                 sticky;
    logic signed [9:0]    e;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic [FP_MANT_W:0]   inc;
`else
    logic                 unused_rnd;
    assign unused_rnd = guard ^ sticky;
`endif

    always_comb begin
        mant   = '0;
        mant_r = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        e      = e_in;
        result = '0;
`ifdef FP_DIV_ROUND_NEAREST_EN
        inc    = '0;
`endif
        // Quotient of two [1,2) significands lies in (0.5,2): at most one left shift.
        if (q[QBITS-1]) begin
            mant   = q[QBITS-2 -: FP_MANT_W];
            guard  = q[QBITS-2-FP_MANT_W];
            sticky = q[QBITS-3-FP_MANT_W] | r_nz;
        end else begin
            mant   = q[QBITS-3 -: FP_MANT_W];
            guard  = q[QBITS-3-FP_MANT_W];
            sticky = r_nz;
            e      = e_in - 10'sd1;
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        inc    = {1'b0, mant} + {{FP_MANT_W{1'b0}}, guard & (sticky | mant[0])};
        mant_r = inc[FP_MANT_W-1:0];
        if (inc[FP_MANT_W])
            e = e + 10'sd1;
`else
        mant_r = mant;
`endif
        if (e >= EMAX)
            result = {sign, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            result = {sign, 31'h0};
        else
            result = {sign, e[FP_EXP_W-1:0], mant_r};
    end
endmodule

// File: rtl/fp_div_core.sv
// Iterative restoring FP32 divider, one quotient bit per clock; normal operands only.
// Rounding mode chosen by FP_DIV_ROUND_NEAREST_EN (see fp_div_round).
module fp_div_core
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] op1_q,
    output logic [31:0] op2_q,
    output logic [31:0] temp_result
);
    localparam int                CNT_W = $clog2(QBITS + 1);
    localparam logic signed [9:0] EBIAS = 10'(FP_EXP_BIAS);

    fp_state_e         state;
    logic [24:0]       r;
    logic [23:0]       mb;
    logic [QBITS-1:0]  q;
    logic [CNT_W-1:0]  cnt;
    logic              sign;
    logic signed [9:0] e;
    logic [24:0]       diff;
    logic              ge;
    logic [31:0]       rnd_res;

    assign ge   = (r >= {1'b0, mb});
    assign diff = r - {1'b0, mb};

    fp_div_round #(.QBITS(QBITS)) u_round (
        .q      (q),
        .r_nz   (|r),
        .e_in   (e),
        .sign   (sign),
        .result (rnd_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            temp_result <= '0;
            r           <= '0;
            mb          <= '0;
            q           <= '0;
            cnt         <= '0;
            sign        <= 1'b0;
            e           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op1_q <= in1;
                        op2_q <= in2;
                        r     <= {2'b01, in1[22:0]};
                        mb    <= {1'b1, in2[22:0]};
                        q     <= '0;
                        cnt   <= '0;
                        sign  <= in1[31] ^ in2[31];
                        e     <= $signed({2'b00, in1[30:23]}) - $signed({2'b00, in2[30:23]}) + EBIAS;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Bits arrive MSB first, so shifting in is q[QBITS-1-cnt].
                    if (cnt == CNT_W'(QBITS)) begin
                        state <= NORM;
                    end else begin
                        q   <= {q[QBITS-2:0], ge};
                        r   <= ge ? {diff[23:0], 1'b0} : {r[23:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end
                end
                NORM: begin
                    temp_result <= rnd_res;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
